// File: rtl/hex_display_arbiter_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// disp_pkg
// Shared types and constants for the seven-segment display arbiter slice.
//   disp_state_e : arbiter state (IDLE, HOLD, OPEN)
//   DIGITS       : number of seven-segment digits on the board
//   NIBBLE_W     : bits per hex digit
//   DISP_W       : width of one requester's display word
//   BLANK_ALL    : per-digit blank mask with every digit dark
//   MAX_REQ      : largest supported requester count (owner index is 3 bits)
// -----------------------------------------------------------------------------
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      OPEN
   } disp_state_e;

   localparam int unsigned       DIGITS    = 8;
   localparam int unsigned       NIBBLE_W  = 4;
   localparam int unsigned       DISP_W    = DIGITS * NIBBLE_W;
   localparam logic [DIGITS-1:0] BLANK_ALL = 8'hFF;
   localparam int unsigned       MAX_REQ   = 8;

endpackage

// File: rtl/hex_display_arbiter_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hex_display_arbiter_if
// Bundles the requester side and the display side of the arbiter.
//   req        : per-requester request level (high while display wanted)
//   data       : requester i digits in bits [32i+31:32i], nibble k -> HEX k
//   grant      : registered one-hot grant, all-zero when idle
//   owner      : index of current/last owner, zero-extended to 3 bits
//   disp_value : registered 32-bit value for the per-digit decoders
//   disp_blank : per-digit blank, 1 = digit dark
// Modports: master = requesters/board top, slave = arbiter.
// -----------------------------------------------------------------------------
interface hex_display_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   import disp_pkg::*;

   logic [NUM_REQ-1:0]        req;
   logic [DISP_W*NUM_REQ-1:0] data;
   logic [NUM_REQ-1:0]        grant;
   logic [2:0]                owner;
   logic [DISP_W-1:0]         disp_value;
   logic [DIGITS-1:0]         disp_blank;

   modport master (
      output req,
      output data,
      input  grant,
      input  owner,
      input  disp_value,
      input  disp_blank
   );

   modport slave (
      input  req,
      input  data,
      output grant,
      output owner,
      output disp_value,
      output disp_blank
   );

endinterface

// File: rtl/hex_display_arbiter_tick_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tick_gen
// Free-running prescaler producing a one-cycle enable pulse every
// 2^TICK_DIV clocks. Consumers use tick as a clock enable; no derived clocks.
//   CLOCK_50 : system clock
//   RESET_N  : asynchronous active-low reset
//   tick     : high for exactly one cycle while the counter is all-ones
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int unsigned TICK_DIV = 22
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   output logic tick
);

   logic [TICK_DIV-1:0] cnt_q;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + TICK_DIV'(1);
      end
   end

   assign tick = &cnt_q;

endmodule

// File: rtl/hex_display_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hex_display_arbiter
// Shares the eight-digit seven-segment display between NUM_REQ requesters
// using round-robin arbitration with a minimum dwell of HOLD_TICKS prescaled
// ticks. A new owner is held for the dwell period (HOLD); afterwards (OPEN)
// any other request moves the grant on. An owner dropping its request always
// returns the arbiter to IDLE, leaving a one-cycle gap before re-arbitration.
//   CLOCK_50 : system clock, 50 MHz
//   RESET_N  : asynchronous active-low reset
//   bus      : slave modport - req/data in, grant/owner/disp_value/disp_blank out
// -----------------------------------------------------------------------------
module hex_display_arbiter
   import disp_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned TICK_DIV   = 22,
   parameter int unsigned HOLD_TICKS = 8
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   hex_display_arbiter_if.slave  bus
);

   localparam int unsigned        DWELL_W   = $clog2(HOLD_TICKS + 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(HOLD_TICKS);
   localparam logic [2:0]         OWNER_RST = 3'(NUM_REQ - 1);

   disp_state_e         state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [2:0]          owner_q, owner_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [DISP_W-1:0]   value_q, value_d;
   logic [DIGITS-1:0]   blank_q, blank_d;

   logic                tick;
   logic [MAX_REQ-1:0]  req_w;
   logic [MAX_REQ-1:0]  owner_oh;
   logic [MAX_REQ-1:0]  cand;
   logic [2:0]          pick_idx;
   logic                pick_valid;
   logic [NUM_REQ-1:0]  pick_grant;
   int unsigned         rr_idx;
   logic [DISP_W-1:0]   slice [MAX_REQ];

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .tick     (tick)
   );

   // Requester words padded to MAX_REQ entries so a 3-bit owner index
   // always selects a defined word.
   for (genvar i = 0; i < MAX_REQ; i++) begin : g_slice
      if (i < NUM_REQ) begin : g_used
         assign slice[i] = bus.data[i*DISP_W +: DISP_W];
      end else begin : g_unused
         assign slice[i] = '0;
      end
   end

   assign req_w    = MAX_REQ'(bus.req);
   assign owner_oh = MAX_REQ'(1) << owner_q;

   // In OPEN the owner is excluded so an active owner never re-wins itself;
   // in IDLE the owner is the last candidate of the rotation.
   assign cand = (state_q == OPEN) ? (req_w & ~owner_oh) : req_w;

   // Round-robin search starting at owner+1, wrapping modulo NUM_REQ.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = owner_q;
      rr_idx     = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         rr_idx = (32'(owner_q) + k) % NUM_REQ;
         if (!pick_valid && cand[rr_idx[2:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = rr_idx[2:0];
         end
      end
   end

   always_comb begin
      pick_grant = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pick_grant[i] = (32'(pick_idx) == i);
      end
   end

   // Next-state logic. A dropped owner request takes priority over both the
   // dwell tick and any competing request.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      dwell_d = dwell_q;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = HOLD;
               grant_d = pick_grant;
               owner_d = pick_idx;
               dwell_d = '0;
            end
         end

         HOLD: begin
            if (!req_w[owner_q]) begin
               state_d = IDLE;
               grant_d = '0;
            end else if (tick && (dwell_q != DWELL_MAX)) begin
               dwell_d = dwell_q + DWELL_W'(1);
               if (dwell_d == DWELL_MAX) begin
                  state_d = OPEN;
               end
            end
         end

         OPEN: begin
            if (!req_w[owner_q]) begin
               state_d = IDLE;
               grant_d = '0;
            end else if (pick_valid) begin
               state_d = HOLD;
               grant_d = pick_grant;
               owner_d = pick_idx;
               dwell_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
            dwell_d = '0;
         end
      endcase
   end

   // Display follows the current owner with one cycle of latency; blanking
   // is derived from the next state so it switches on the same edge as grant.
   always_comb begin
      value_d = value_q;
      if (state_q != IDLE) begin
         value_d = slice[owner_q];
      end
      blank_d = (state_d == IDLE) ? BLANK_ALL : '0;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= OWNER_RST;
         dwell_q <= '0;
         value_q <= '0;
         blank_q <= BLANK_ALL;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         dwell_q <= dwell_d;
         value_q <= value_d;
         blank_q <= blank_d;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.owner      = owner_q;
   assign bus.disp_value = value_q;
   assign bus.disp_blank = blank_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
`timescale 1ns/1ps
module tb_hex_display_arbiter;
   import disp_pkg::*;

   localparam int NR = 4;
   localparam int TD = 2;
   localparam int HT = 2;
   localparam int TICK_PERIOD = 1 << TD;

   logic CLOCK_50 = 1'b0;
   logic RESET_N  = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   hex_display_arbiter_if #(.NUM_REQ(NR)) bus ();

   hex_display_arbiter #(
      .NUM_REQ    (NR),
      .TICK_DIV   (TD),
      .HOLD_TICKS (HT)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .bus      (bus)
   );

   // Reference model: who holds the display, for how many ticks, and what
   // the decoders show; ticks come from the number of edges since reset.
   bit          m_active   = 1'b0;
   int          m_owner    = NR - 1;
   int          m_held     = 0;
   int          m_edges    = 0;
   logic [31:0] m_val      = '0;
   logic [7:0]  m_blank    = 8'hFF;
   bit          m_was_active;
   bit          m_tick;
   int          m_old_owner;
   int          m_p;

   function automatic int rr_pick(input logic [NR-1:0] r, input int from, input bit excl);
      for (int k = 1; k <= NR; k++) begin
         int i;
         i = (from + k) % NR;
         if (r[i] && !(excl && i == from)) return i;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] exp_grant();
      logic [NR-1:0] g;
      g = '0;
      if (m_active) g[m_owner] = 1'b1;
      return g;
   endfunction

   always @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         m_active = 1'b0;
         m_owner  = NR - 1;
         m_held   = 0;
         m_edges  = 0;
         m_val    = '0;
         m_blank  = 8'hFF;
      end else begin
         m_tick       = ((m_edges % TICK_PERIOD) == TICK_PERIOD - 1);
         m_was_active = m_active;
         m_old_owner  = m_owner;
         if (!m_active) begin
            m_p = rr_pick(bus.req, m_owner, 1'b0);
            if (m_p >= 0) begin
               m_active = 1'b1;
               m_owner  = m_p;
               m_held   = 0;
            end
         end else if (!bus.req[m_owner]) begin
            m_active = 1'b0;
         end else if (m_held < HT) begin
            if (m_tick) m_held++;
         end else begin
            m_p = rr_pick(bus.req, m_owner, 1'b1);
            if (m_p >= 0) begin
               m_owner = m_p;
               m_held  = 0;
            end
         end
         if (m_was_active) m_val = bus.data[m_old_owner*32 +: 32];
         m_blank = m_active ? 8'h00 : 8'hFF;
         m_edges++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge CLOCK_50);
      check("grant", 64'(bus.grant), 64'(exp_grant()));
      check("owner", 64'(bus.owner), 64'(m_owner));
      check("disp_value", 64'(bus.disp_value), 64'(m_val));
      check("disp_blank", 64'(bus.disp_blank), 64'(m_blank));
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      bus.req = '0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      check("rst_grant", 64'(bus.grant), 64'(0));
      check("rst_owner", 64'(bus.owner), 64'(NR - 1));
      check("rst_value", 64'(bus.disp_value), 64'(0));
      check("rst_blank", 64'(bus.disp_blank), 64'(8'hFF));
      RESET_N = 1'b1;
   endtask

   initial begin
      logic [NR-1:0] prev;
      logic [NR-1:0] seq [$];
      logic [NR-1:0] exp_seq [5];
      logic [31:0]   d;
      int            run;
      int            changes;

      bus.req  = '0;
      bus.data = {$urandom, $urandom, $urandom, $urandom};
      #1;

      // 1: first grant and display latency
      do_reset();
      bus.data = {$urandom, $urandom, $urandom, 32'h12345678};
      bus.req  = 4'b0001;
      step();
      check("s1_grant", 64'(bus.grant), 64'(4'b0001));
      check("s1_owner", 64'(bus.owner), 64'(0));
      step();
      check("s1_value", 64'(bus.disp_value), 64'(32'h12345678));
      check("s1_blank", 64'(bus.disp_blank), 64'(0));

      // 2: two requesters alternate without idle gaps
      bus.req = 4'b0101;
      prev    = bus.grant;
      run     = 0;
      changes = 0;
      repeat (80) begin
         step();
         check("s2_nonzero", 64'(|bus.grant), 64'(1));
         if (bus.grant == prev) begin
            run++;
         end else begin
            if (changes > 0)
               check("s2_dwell", 64'((run >= (HT-1)*TICK_PERIOD + 2) && (run <= (HT+1)*TICK_PERIOD)), 64'(1));
            changes++;
            prev = bus.grant;
            run  = 1;
         end
      end
      check("s2_switched", 64'(changes >= 4), 64'(1));

      // 3: owner drop during HOLD beats a waiting request
      do_reset();
      bus.req = 4'b0001;
      step();
      check("s3_grant0", 64'(bus.grant), 64'(4'b0001));
      bus.req = 4'b0100;
      step();
      check("s3_gap_grant", 64'(bus.grant), 64'(0));
      check("s3_gap_blank", 64'(bus.disp_blank), 64'(8'hFF));
      step();
      check("s3_grant2", 64'(bus.grant), 64'(4'b0100));

      // 4: all requesters, pointer wraps
      do_reset();
      bus.req = 4'b1111;
      seq.delete();
      prev = '0;
      repeat (80) begin
         step();
         if (bus.grant != prev && bus.grant != '0) seq.push_back(bus.grant);
         prev = bus.grant;
      end
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      check("s4_len", 64'(seq.size() >= 5), 64'(1));
      for (int i = 0; i < 5; i++)
         if (i < seq.size()) check("s4_seq", 64'(seq[i]), 64'(exp_seq[i]));

      // 5: asynchronous reset mid-HOLD
      do_reset();
      bus.req = 4'b0010;
      step();
      check("s5_grant1", 64'(bus.grant), 64'(4'b0010));
      step();
      @(posedge CLOCK_50);
      #2 RESET_N = 1'b0;
      #1;
      check("s5_async_grant", 64'(bus.grant), 64'(0));
      check("s5_async_value", 64'(bus.disp_value), 64'(0));
      check("s5_async_blank", 64'(bus.disp_blank), 64'(8'hFF));
      check("s5_async_owner", 64'(bus.owner), 64'(NR - 1));
      @(negedge CLOCK_50);
      RESET_N = 1'b1;
      step();
      check("s5_regrant", 64'(bus.grant), 64'(4'b0010));
      check("s5_reowner", 64'(bus.owner), 64'(1));

      // 6: single requester held for 20 ticks, display tracks data
      do_reset();
      bus.req = 4'b0001;
      step();
      step();
      repeat (20 * TICK_PERIOD) begin
         d = $urandom;
         bus.data[31:0] = d;
         step();
         check("s6_grant", 64'(bus.grant), 64'(4'b0001));
         check("s6_track", 64'(bus.disp_value), 64'(d));
      end

      // Random traffic against the model
      do_reset();
      repeat (1500) begin
         if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom_range(0, 15));
         bus.data = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
